// File: rtl/round_scheduler.sv
// Round sequencer for the reaction game: picks a lamp per round, times the response
// window, judges button edges, keeps score/miss/round counts and ends the game.
module round_scheduler #(
    parameter int CNT_W      = 26,
    parameter int WIN_INIT   = 25000000,
    parameter int WIN_STEP   = 2500000,
    parameter int WIN_MIN    = 5000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int ROUNDS     = 20,
    parameter int MAX_MISS   = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] rnd_i,
    input  logic [3:0] btn_i,
    output logic [3:0] lights_o,
    output logic [6:0] score_o,
    output logic [4:0] round_cnt_o,
    output logic [3:0] miss_cnt_o,
    output logic       hit_pulse_o,
    output logic       miss_pulse_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHOW,
        S_HIT,
        S_MISS,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] WIN_INIT_C = CNT_W'(WIN_INIT);
    localparam logic [CNT_W-1:0] WIN_STEP_C = CNT_W'(WIN_STEP);
    localparam logic [CNT_W-1:0] WIN_MIN_C  = CNT_W'(WIN_MIN);
    localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W:0]   SHRINK_TH  = (CNT_W+1)'(WIN_MIN + WIN_STEP);
    localparam logic [4:0]       ROUNDS_C   = 5'(ROUNDS);
    localparam logic [3:0]       MAX_MISS_C = 4'(MAX_MISS);

    function automatic logic [6:0] score_inc(input logic [6:0] s);
        return (s >= 7'd99) ? 7'd99 : s + 7'd1;
    endfunction

    // Shrink by one step but never below the floor; compare one bit wider to avoid wrap.
    function automatic logic [CNT_W-1:0] window_shrink(input logic [CNT_W-1:0] w);
        if ({1'b0, w} >= SHRINK_TH) begin
            return w - WIN_STEP_C;
        end
        return WIN_MIN_C;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] t);
        return 4'b0001 << t;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       btn_q;
    logic [1:0]       tgt_q, tgt_d;
    logic             prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] window_q, window_d;
    logic [6:0]       score_q, score_d;
    logic [4:0]       round_q, round_d;
    logic [3:0]       miss_q, miss_d;
    logic [3:0]       lights_q, lights_d;
    logic             hit_q, hit_d;
    logic             missp_q, missp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       press;
    logic             unused_rnd;

    assign press      = btn_i & ~btn_q;
    assign unused_rnd = &{1'b0, rnd_i[3:2]};

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        prev_vld_d = prev_vld_q;
        timer_d    = timer_q;
        window_d   = window_q;
        score_d    = score_q;
        round_d    = round_q;
        miss_d     = miss_q;
        hit_d      = 1'b0;
        missp_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    score_d    = '0;
                    round_d    = '0;
                    miss_d     = '0;
                    window_d   = WIN_INIT_C;
                    prev_vld_d = 1'b0;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                // tgt_q still holds the previous round's lamp; bump to avoid a repeat.
                tgt_d = rnd_i[1:0];
                if (prev_vld_q && (rnd_i[1:0] == tgt_q)) begin
                    tgt_d = rnd_i[1:0] + 2'd1;
                end
                prev_vld_d = 1'b1;
                timer_d    = window_q;
                state_d    = S_SHOW;
            end
            S_SHOW: begin
                if (press == onehot(tgt_q)) begin
                    state_d  = S_HIT;
                    hit_d    = 1'b1;
                    score_d  = score_inc(score_q);
                    round_d  = round_q + 5'd1;
                    window_d = window_shrink(window_q);
                end else if ((press != 4'b0000) || (timer_q <= CNT_W'(1))) begin
                    state_d = S_MISS;
                    missp_d = 1'b1;
                    miss_d  = miss_q + 4'd1;
                    round_d = round_q + 5'd1;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            S_HIT, S_MISS: begin
                timer_d = GAP_C;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end else if (btn_i == 4'b0000) begin
                    if ((round_q == ROUNDS_C) || (miss_q == MAX_MISS_C)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        lights_d = (state_d == S_SHOW) ? onehot(tgt_d) : 4'b0000;
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            btn_q      <= '0;
            tgt_q      <= '0;
            prev_vld_q <= 1'b0;
            timer_q    <= '0;
            window_q   <= WIN_INIT_C;
            score_q    <= '0;
            round_q    <= '0;
            miss_q     <= '0;
            lights_q   <= '0;
            hit_q      <= 1'b0;
            missp_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_i;
            tgt_q      <= tgt_d;
            prev_vld_q <= prev_vld_d;
            timer_q    <= timer_d;
            window_q   <= window_d;
            score_q    <= score_d;
            round_q    <= round_d;
            miss_q     <= miss_d;
            lights_q   <= lights_d;
            hit_q      <= hit_d;
            missp_q    <= missp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign lights_o     = lights_q;
    assign score_o      = score_q;
    assign round_cnt_o  = round_q;
    assign miss_cnt_o   = miss_q;
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = missp_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
